// File: rtl/uart_tx_fifo.sv
// UART transmitter that drains an upstream FIFO one word per frame: start bit, DATA_WIDTH bits LSB first, stop bit.
// Latency: 3 cycles from a non-empty FIFO to the start bit edge; back-to-back frame period (DATA_WIDTH+2)*CLKS_PER_BIT+3.
// Backpressure: pops only from IDLE when fifo_empty is low, one single-cycle pop per frame; FIFO is held off for the whole frame.
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_req,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    // tx is computed one cycle ahead so the line itself is always a flop output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_read_req = rd_q;
    assign tx            = tx_q;
    assign tx_done       = done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a 4-deep registered-read FIFO model and a per-cycle frame sampler.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_req;
    logic       tx;
    logic       busy;
    logic       tx_done;

    // FIFO model (4 entries, registered read data) plus an empty-override for hold-off and toggling.
    logic [7:0] fmem [4];
    logic [1:0] wp, rp;
    logic [2:0] fcnt;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tog_en, tog_val;
    logic       do_wr, do_rd;
    int         pops = 0;
    int         underflows = 0;
    int         cyc = 0;
    int         tests_run = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_req(fifo_read_req),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    assign do_wr      = wr_en && (fcnt != 3'd4);
    assign do_rd      = fifo_read_req && (fcnt != 3'd0);
    assign fifo_empty = tog_en ? tog_val : (fcnt == 3'd0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_req) pops <= pops + 1;
        if (fifo_read_req && fcnt == 3'd0) underflows <= underflows + 1;
        if (reset) begin
            wp <= 2'd0; rp <= 2'd0; fcnt <= 3'd0; fifo_data <= 8'd0;
        end else begin
            if (do_wr) begin fmem[wp] <= wr_data; wp <= wp + 2'd1; end
            if (do_rd) begin fifo_data <= fmem[rp]; rp <= rp + 2'd1; end
            fcnt <= fcnt + {2'b0, do_wr} - {2'b0, do_rd};
        end
    end

    // Called at a negedge; leaves one write request active across the next rising edge.
    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Measures one frame: waits for the start bit, records 40 cycle-level samples, then the done pulse.
    task automatic capture(output logic [7:0] data, output logic shape_ok, output logic busy_ok,
                           output logic done_ok, output int start_cyc, output logic found);
        logic [FRAME-1:0] lv;
        found = 1'b0; shape_ok = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; data = 8'h00; start_cyc = 0; lv = '0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        if (!found) return;
        start_cyc = cyc;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            lv[c] = tx;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (tx_done !== 1'b0) done_ok = 1'b0;
        end
        for (int c = 0; c < FRAME; c++)
            if (lv[c] !== lv[(c / CPB) * CPB]) shape_ok = 1'b0;
        if (lv[0] !== 1'b0 || lv[FRAME-1] !== 1'b1) shape_ok = 1'b0;
        for (int b = 0; b < 8; b++) data[b] = lv[CPB * (b + 1)];
        @(negedge clk);
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) done_ok = 1'b0;
        @(negedge clk);
        if (tx_done !== 1'b0) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b exp 1", tx); end
        tests_run++; if (fifo_read_req !== 1'b0) begin fails++; $display("FAIL reset_rdreq got %b exp 0", fifo_read_req); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", tx_done); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_single();
        logic [7:0] d; logic sh, bz, dn, fd; int s, p0;
        p0 = pops;
        push(8'hA5);
        capture(d, sh, bz, dn, s, fd);
        tests_run++; if (fd !== 1'b1) begin fails++; $display("FAIL single_start got %b exp 1", fd); end
        tests_run++; if (d !== 8'hA5) begin fails++; $display("FAIL single_data got %h exp a5", d); end
        tests_run++; if (sh !== 1'b1) begin fails++; $display("FAIL single_bit_timing got %b exp 1", sh); end
        tests_run++; if (bz !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", bz); end
        tests_run++; if (dn !== 1'b1) begin fails++; $display("FAIL single_done_pulse got %b exp 1", dn); end
        tests_run++; if (pops - p0 != 1) begin fails++; $display("FAIL single_pops got %0d exp 1", pops - p0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3]; logic [7:0] d; logic sh, bz, dn, fd; int s [3]; int p0;
        exp_d[0] = 8'h5A; exp_d[1] = 8'hFF; exp_d[2] = 8'h00;
        p0 = pops;
        push(8'h5A); push(8'hFF); push(8'h00);
        for (int k = 0; k < 3; k++) begin
            capture(d, sh, bz, dn, s[k], fd);
            tests_run++; if (d !== exp_d[k] || sh !== 1'b1 || fd !== 1'b1) begin
                fails++; $display("FAIL b2b_frame%0d got %h shape=%b exp %h shape=1", k, d, sh, exp_d[k]);
            end
        end
        tests_run++; if (s[1] - s[0] != 43) begin fails++; $display("FAIL b2b_spacing01 got %0d exp 43", s[1] - s[0]); end
        tests_run++; if (s[2] - s[1] != 43) begin fails++; $display("FAIL b2b_spacing12 got %0d exp 43", s[2] - s[1]); end
        tests_run++; if (pops - p0 != 3) begin fails++; $display("FAIL b2b_pops got %0d exp 3", pops - p0); end
    endtask

    task automatic test_empty();
        logic any_req, any_low, any_busy;
        any_req = 1'b0; any_low = 1'b0; any_busy = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_read_req !== 1'b0) any_req = 1'b1;
            if (tx !== 1'b1) any_low = 1'b1;
            if (busy !== 1'b0) any_busy = 1'b1;
        end
        tests_run++; if (any_req !== 1'b0) begin fails++; $display("FAIL empty_rdreq got %b exp 0", any_req); end
        tests_run++; if (any_low !== 1'b0) begin fails++; $display("FAIL empty_tx_low got %b exp 0", any_low); end
        tests_run++; if (any_busy !== 1'b0) begin fails++; $display("FAIL empty_busy got %b exp 0", any_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d; logic sh, bz, dn, fd; int s, p0;
        p0 = pops; fd = 1'b0;
        push(8'hCC);
        for (int i = 0; i < 50 && !fd; i++) begin
            @(negedge clk);
            if (tx === 1'b0) fd = 1'b1;
        end
        tests_run++; if (fd !== 1'b1) begin fails++; $display("FAIL midrst_start got %b exp 1", fd); end
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_state got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++; if (pops - p0 != 1) begin fails++; $display("FAIL midrst_no_reread got %0d exp 1", pops - p0); end
        push(8'h3C);
        capture(d, sh, bz, dn, s, fd);
        tests_run++; if (d !== 8'h3C || sh !== 1'b1) begin fails++; $display("FAIL midrst_next_frame got %h shape=%b exp 3c shape=1", d, sh); end
    endtask

    task automatic test_empty_toggle();
        logic [7:0] d; logic sh, bz, dn, fd, seen; int s, p0, u0;
        p0 = pops; u0 = underflows; seen = 1'b0;
        push(8'h81);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (fifo_read_req === 1'b1) seen = 1'b1; else @(negedge clk);
        end
        tog_val = 1'b0; tog_en = 1'b1;
        fork
            capture(d, sh, bz, dn, s, fd);
            begin
                repeat (38) begin @(negedge clk); tog_val = ~tog_val; end
                tog_en = 1'b0;
            end
        join
        tests_run++; if (d !== 8'h81 || sh !== 1'b1) begin fails++; $display("FAIL toggle_frame got %h shape=%b exp 81 shape=1", d, sh); end
        repeat (5) @(negedge clk);
        tests_run++; if (pops - p0 != 1) begin fails++; $display("FAIL toggle_pops got %0d exp 1", pops - p0); end
        tests_run++; if (underflows != u0) begin fails++; $display("FAIL toggle_underflow got %0d exp %0d", underflows, u0); end
    endtask

    task automatic test_end_to_end();
        logic [7:0] exp_d [4]; logic [7:0] d; logic sh, bz, dn, fd; int s, p0;
        exp_d[0] = 8'hA5; exp_d[1] = 8'h5A; exp_d[2] = 8'hFF; exp_d[3] = 8'h00;
        p0 = pops;
        tog_val = 1'b1; tog_en = 1'b1;
        push(8'hA5); push(8'h5A); push(8'hFF); push(8'h00); push(8'h11);
        tests_run++; if (fcnt !== 3'd4) begin fails++; $display("FAIL e2e_full got %0d exp 4", fcnt); end
        tests_run++; if (pops != p0) begin fails++; $display("FAIL e2e_held_pops got %0d exp 0", pops - p0); end
        tog_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            capture(d, sh, bz, dn, s, fd);
            tests_run++; if (d !== exp_d[k] || sh !== 1'b1 || dn !== 1'b1) begin
                fails++; $display("FAIL e2e_frame%0d got %h shape=%b done=%b exp %h", k, d, sh, dn, exp_d[k]);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++; if (fifo_empty !== 1'b1 || fcnt !== 3'd0) begin fails++; $display("FAIL e2e_drained got empty=%b cnt=%0d exp 1/0", fifo_empty, fcnt); end
        tests_run++; if (pops - p0 != 4) begin fails++; $display("FAIL e2e_pops got %0d exp 4", pops - p0); end
        tests_run++; if (underflows != 0) begin fails++; $display("FAIL underflow_total got %0d exp 0", underflows); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tog_en = 1'b0; tog_val = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_reset_mid_frame();
        test_empty_toggle();
        test_end_to_end();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
